avalon_ram: RTL and testbench

AVALON_RAM -- requirements
Module: avalon_ram

---
 rtl/avalon_ram_if.sv | 26 ++
 rtl/avalon_ram.sv | 93 +++++++++
 tb/tb_avalon_ram.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_ram_if.sv
`default_nettype none
// ============================================================================
// Module      : avalon_ram_if
// Description : Avalon-MM slave bus bundle for the 64-word instruction/data RAM.
// Revision    : 1.0 - initial release
// ============================================================================
interface avalon_ram_if;
    logic [31:0] address;
    logic        write;
    logic        read;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;

    modport master (
        output address, write, read, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, write, read, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface
`default_nettype wire

// File: rtl/avalon_ram.sv
`default_nettype none
// ============================================================================
// Module      : avalon_ram
// Description : 64 x 32-bit RAM with an Avalon-MM slave port (one wait cycle
//               per access) and a clock-independent level-sensitive preload.
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_ram (
    input  wire logic        clk,
    input  wire logic        RAM_Reset,
    avalon_ram_if.slave      bus,
    input  wire logic [31:0] instruction,
    input  wire logic        inst_input,
    input  wire logic [7:0]  inst_addr
);

    localparam int c_WORDS = 64;

    logic [c_WORDS-1:0][31:0] r_bus_mem;
    logic [c_WORDS-1:0]       r_bus_tag;
    logic [c_WORDS-1:0]       w_pre_tag;
    logic [c_WORDS-1:0]       w_pre_sel;
    logic [c_WORDS-1:0][31:0] w_word;
    logic                     r_ack;
    logic                     w_req;
    logic                     w_wait;
    logic                     w_bus_we;
    logic [5:0]               w_bus_idx;
    logic [5:0]               w_pre_idx;
    logic [31:0]              w_merged;
    logic                     w_unused_addr;

    assign w_bus_idx     = bus.address[7:2];
    assign w_pre_idx     = inst_addr[7:2];
    assign w_unused_addr = ^{bus.address[31:8], bus.address[1:0], inst_addr[1:0]};

    // Each word has a clocked bus copy and a latched preload copy; the copy
    // whose tag was written last wins (tags differ => preload is newer).
    generate
        for (genvar gi = 0; gi < c_WORDS; gi++) begin : g_word
            logic [31:0] r_pre_word;
            logic        r_pre_tag;

            assign w_pre_sel[gi] = inst_input & RAM_Reset & (w_pre_idx == 6'(gi));

            always_latch begin
                if (!RAM_Reset) begin
                    r_pre_word = '0;
                    r_pre_tag  = 1'b0;
                end else if (w_pre_sel[gi]) begin
                    r_pre_word = instruction;
                    r_pre_tag  = ~r_bus_tag[gi];
                end
            end

            assign w_pre_tag[gi] = r_pre_tag;
            assign w_word[gi]    = (r_pre_tag != r_bus_tag[gi]) ? r_pre_word : r_bus_mem[gi];
        end
    endgenerate

    assign w_req  = bus.read | bus.write;
    assign w_wait = w_req & ~r_ack;
    // An active preload to the same word blocks the bus write in that cycle.
    assign w_bus_we = bus.write & r_ack & ~w_pre_sel[w_bus_idx];

    always_comb begin
        w_merged = w_word[w_bus_idx];
        for (int b = 0; b < 4; b++) begin
            if (bus.byteenable[b]) begin
                w_merged[8*b +: 8] = bus.writedata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge RAM_Reset) begin
        if (!RAM_Reset) begin
            r_ack     <= 1'b0;
            r_bus_mem <= '0;
            r_bus_tag <= '0;
        end else begin
            r_ack <= w_req & ~r_ack;
            if (w_bus_we) begin
                r_bus_mem[w_bus_idx] <= w_merged;
                r_bus_tag[w_bus_idx] <= w_pre_tag[w_bus_idx];
            end
        end
    end

    assign bus.waitrequest = w_wait;
    assign bus.readdata    = (bus.read & ~w_wait) ? w_word[w_bus_idx] : 32'h0000_0000;

endmodule
`default_nettype wire

// File: tb/tb_avalon_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_avalon_ram
// Description : Directed self-checking bench for avalon_ram.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_ram;

    logic        clk;
    logic        RAM_Reset;
    logic [31:0] instruction;
    logic        inst_input;
    logic [7:0]  inst_addr;
    int          n_checks;
    int          n_fail;

    avalon_ram_if bus ();

    avalon_ram u_dut (
        .clk         (clk),
        .RAM_Reset   (RAM_Reset),
        .bus         (bus),
        .instruction (instruction),
        .inst_input  (inst_input),
        .inst_addr   (inst_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Every access starts just after a rising edge and leaves the bus idle.
    task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
        bus.address = a;
        bus.read    = 1'b1;
        @(negedge clk);
        chk({tag, "_wait"}, {31'b0, bus.waitrequest}, 32'd1);
        chk({tag, "_rd0"}, bus.readdata, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_acc"}, {31'b0, bus.waitrequest}, 32'd0);
        chk({tag, "_data"}, bus.readdata, exp);
        @(posedge clk);
        #1;
        bus.read = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] be, input string tag);
        bus.address    = a;
        bus.writedata  = d;
        bus.byteenable = be;
        bus.write      = 1'b1;
        @(negedge clk);
        chk({tag, "_wait"}, {31'b0, bus.waitrequest}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_acc"}, {31'b0, bus.waitrequest}, 32'd0);
        @(posedge clk);
        #1;
        bus.write = 1'b0;
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        RAM_Reset      = 1'b0;
        instruction    = '0;
        inst_input     = 1'b0;
        inst_addr      = '0;
        bus.address    = '0;
        bus.write      = 1'b0;
        bus.read       = 1'b0;
        bus.writedata  = '0;
        bus.byteenable = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_idle_wait", {31'b0, bus.waitrequest}, 32'd0);
        chk("rst_idle_rd", bus.readdata, 32'h0);
        bus.read    = 1'b1;
        bus.address = 32'h4;
        #1;
        chk("rst_req_wait", {31'b0, bus.waitrequest}, 32'd1);
        @(posedge clk);
        #1;
        chk("rst_hold_wait", {31'b0, bus.waitrequest}, 32'd1);
        chk("rst_hold_rd", bus.readdata, 32'h0);
        bus.read  = 1'b0;
        RAM_Reset = 1'b1;
        @(posedge clk);
        #1;

        bus_read(32'h0000_0004, 32'h0, "rd_after_rst");

        // Three preloads between clock edges, one time unit apart.
        inst_input  = 1'b1;
        inst_addr   = 8'h04;
        instruction = 32'h2403_2468;
        #1;
        inst_addr   = 8'h08;
        instruction = 32'h3062_FFFF;
        #1;
        inst_addr   = 8'h0C;
        instruction = 32'h0000_0008;
        #1;
        inst_input  = 1'b0;
        @(posedge clk);
        #1;
        bus_read(32'hBFC0_0004, 32'h2403_2468, "pre_04");
        bus_read(32'hBFC0_0008, 32'h3062_FFFF, "pre_08");
        bus_read(32'hBFC0_000C, 32'h0000_0008, "pre_0C");

        bus_write(32'h10, 32'hAABB_CCDD, 4'b1111, "wr_full");
        bus_write(32'h10, 32'h1122_3344, 4'b0101, "wr_part");
        bus_read(32'h10, 32'hAA22_CCDD & 32'hFFFF_FF00 | 32'h44, "rd_merge");

        // Read held high across two addresses.
        bus.address = 32'h04;
        bus.read    = 1'b1;
        @(negedge clk);
        chk("b2b_w0", {31'b0, bus.waitrequest}, 32'd1);
        chk("b2b_d0", bus.readdata, 32'h0);
        @(negedge clk);
        chk("b2b_w1", {31'b0, bus.waitrequest}, 32'd0);
        chk("b2b_d1", bus.readdata, 32'h2403_2468);
        @(posedge clk);
        #1;
        bus.address = 32'h08;
        @(negedge clk);
        chk("b2b_w2", {31'b0, bus.waitrequest}, 32'd1);
        chk("b2b_d2", bus.readdata, 32'h0);
        @(negedge clk);
        chk("b2b_w3", {31'b0, bus.waitrequest}, 32'd0);
        chk("b2b_d3", bus.readdata, 32'h3062_FFFF);
        @(posedge clk);
        #1;
        bus.read = 1'b0;

        // Simultaneous read and write: the read sees the old word.
        bus.address    = 32'h20;
        bus.writedata  = 32'h1234_5678;
        bus.byteenable = 4'b1111;
        bus.read       = 1'b1;
        bus.write      = 1'b1;
        @(negedge clk);
        chk("rw_wait", {31'b0, bus.waitrequest}, 32'd1);
        @(negedge clk);
        chk("rw_acc", {31'b0, bus.waitrequest}, 32'd0);
        chk("rw_old", bus.readdata, 32'h0);
        @(posedge clk);
        #1;
        bus.read  = 1'b0;
        bus.write = 1'b0;
        bus_read(32'h20, 32'h1234_5678, "rw_new");

        // Preload and bus write hit the same word on the same edge.
        bus.address    = 32'h24;
        bus.writedata  = 32'h1111_1111;
        bus.byteenable = 4'b1111;
        bus.write      = 1'b1;
        @(negedge clk);
        chk("prio_wait", {31'b0, bus.waitrequest}, 32'd1);
        @(posedge clk);
        #1;
        inst_input  = 1'b1;
        inst_addr   = 8'h24;
        instruction = 32'h5555_5555;
        @(negedge clk);
        chk("prio_acc", {31'b0, bus.waitrequest}, 32'd0);
        @(posedge clk);
        #1;
        inst_input = 1'b0;
        bus.write  = 1'b0;
        bus_read(32'h24, 32'h5555_5555, "prio_rd");
        bus_write(32'h24, 32'hAAAA_AAAA, 4'b0011, "post_pre_wr");
        bus_read(32'h24, 32'h5555_AAAA, "post_pre_rd");

        // Reset asserted during the accept cycle of a write.
        bus.address    = 32'h30;
        bus.writedata  = 32'hDEAD_BEEF;
        bus.byteenable = 4'b1111;
        bus.write      = 1'b1;
        @(negedge clk);
        chk("abort_wait", {31'b0, bus.waitrequest}, 32'd1);
        @(posedge clk);
        #1;
        chk("abort_acc", {31'b0, bus.waitrequest}, 32'd0);
        RAM_Reset   = 1'b0;
        inst_input  = 1'b1;
        inst_addr   = 8'h14;
        instruction = 32'h7777_7777;
        #1;
        chk("abort_rewait", {31'b0, bus.waitrequest}, 32'd1);
        chk("abort_rd", bus.readdata, 32'h0);
        @(posedge clk);
        #1;
        chk("abort_hold", {31'b0, bus.waitrequest}, 32'd1);
        bus.write  = 1'b0;
        inst_input = 1'b0;
        #1;
        RAM_Reset = 1'b1;
        @(posedge clk);
        #1;
        bus_read(32'h30, 32'h0, "abort_word");
        bus_read(32'h04, 32'h0, "clr_pre");
        bus_read(32'h10, 32'h0, "clr_bus");
        bus_read(32'h14, 32'h0, "clr_rst_pre");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
